// File: rtl/pepe_pkg.sv
// Shared types and constants for the pad adder sequencer:
// FSM states, operation codes and status byte layout.
package pepe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STAT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int ST_CARRY = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_ZERO  = 2;

    function automatic logic [7:0] status_byte(input logic zero, input logic ovf, input logic carry);
        logic [7:0] s;
        s = 8'd0;
        s[ST_ZERO]  = zero;
        s[ST_OVF]   = ovf;
        s[ST_CARRY] = carry;
        return s;
    endfunction

endpackage

// File: rtl/pepe_byte_alu.sv
// Combinational 8-bit adder slice; subtract is done by inverting b and
// feeding the carry register (preset to 1) as carry-in.
module pepe_byte_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       inv_b,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf
);

    logic [7:0] b_eff;

    assign b_eff       = inv_b ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
    // Signed overflow as seen from the top byte of a multi-byte operand.
    assign ovf         = (a[7] == b_eff[7]) && (sum[7] != a[7]);

endmodule

// File: rtl/pepe_serial_add_ctrl.sv
// Byte-serial NBYTES-wide add/subtract sequencer: one operand byte pair per
// beat, LSB first, sum bytes then a status byte on a 1-entry output register.
module pepe_serial_add_ctrl
    import pepe_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       op_sub,
    input  logic       in_valid,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBYTES - 1);

    // Handshakes: a transfer happens on a rising clk where valid && ready;
    // valid never waits on ready, and ready here never looks at in_valid.

    state_t        state, state_nxt;
    logic          op_q;
    logic          carry;
    logic [BW-1:0] beat;
    logic          zero_acc;
    logic          ovf_q;

    logic          accept;
    logic          last_beat;
    logic          start_op;
    logic          load_sum;
    logic          load_stat;

    logic [7:0]    alu_sum;
    logic          alu_cout;
    logic          alu_ovf;

    pepe_byte_alu u_alu (
        .a     (in_a),
        .b     (in_b),
        .cin   (carry),
        .inv_b (op_q),
        .sum   (alu_sum),
        .cout  (alu_cout),
        .ovf   (alu_ovf)
    );

    assign in_ready  = ena && (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        start_op  = 1'b0;
        load_sum  = 1'b0;
        load_stat = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_op  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    load_sum = 1'b1;
                    if (last_beat) state_nxt = STAT;
                end
            end
            STAT: begin
                if (!out_valid || out_ready) begin
                    load_stat = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            carry     <= 1'b0;
            beat      <= '0;
            zero_acc  <= 1'b1;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
        end else if (ena) begin
            state <= state_nxt;
            if (start_op) begin
                op_q     <= op_sub;
                carry    <= op_sub;
                beat     <= '0;
                zero_acc <= 1'b1;
                ovf_q    <= 1'b0;
            end
            // A load replaces the current byte even when it drains this edge.
            if (load_sum) begin
                out_data  <= alu_sum;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                carry     <= alu_cout;
                zero_acc  <= zero_acc && (alu_sum == 8'd0);
                beat      <= beat + BW'(1);
                if (last_beat) ovf_q <= alu_ovf;
            end else if (load_stat) begin
                out_data  <= status_byte(zero_acc, ovf_q, carry);
                out_valid <= 1'b1;
                out_last  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pepe_serial_add_ctrl.sv
// Bench for pepe_serial_add_ctrl: table vectors, hand-written corner
// sequences and randomized operations checked against a 32-bit model.
module tb_pepe_serial_add_ctrl;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, op_sub, in_valid;
    logic [7:0] in_a, in_b;
    logic       in_ready, out_valid, out_last, out_ready, busy;
    logic [7:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    bit         prev_stall = 1'b0;
    bit         prev_acc   = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic       prev_last  = 1'b0;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  st;
    } vec_t;

    vec_t vecs[5];

    pepe_serial_add_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .op_sub    (op_sub),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, status derived from the result.
    function automatic logic [39:0] model(input bit op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        bit          c, v;
        if (op) begin
            r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            c    = wide[32];
            v    = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {5'b0, (r == 32'd0), v, c, r};
    endfunction

    // Called #1 after a negedge, once inputs for the coming posedge are set.
    task automatic sample_outputs(output bit acc);
        logic [8:0] e;
        if (prev_stall && out_valid) begin
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
        end
        if (prev_acc) begin
            check("latency_valid", out_valid, 1);
            check("latency_last", out_last, 0);
        end
        if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected nothing", {out_last, out_data});
            end else begin
                e = exp_q.pop_front();
                check("out_byte", {23'd0, out_last, out_data}, {23'd0, e});
            end
        end
        acc        = in_valid && in_ready;
        prev_acc   = acc;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    // mode 0: full rate, 1: out_ready low 5 cycles after first accept, 2: random gaps
    task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [7:0] es, input int mode);
        int idx   = 0;
        int stall = 0;
        int n     = 0;
        int first = -1;
        int last  = -1;
        int ix;
        bit acc;
        bit seen_acc = 1'b0;
        for (int i = 0; i < NB; i++) exp_q.push_back({1'b0, er[8*i +: 8]});
        exp_q.push_back({1'b1, es});
        @(negedge clk);
        start = 1'b1; op_sub = op; in_valid = 1'b0; out_ready = 1'b1;
        #1 sample_outputs(acc);
        @(negedge clk);
        start = 1'b0; op_sub = 1'($urandom_range(0, 1));
        #1 sample_outputs(acc);
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
            ix       = (idx < NB) ? idx : 0;
            in_valid = (idx < NB) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_a     = a[8*ix +: 8];
            in_b     = b[8*ix +: 8];
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(seen_acc && stall < 5);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1 sample_outputs(acc);
            if (mode == 1 && !out_ready) begin
                stall++;
                check("bp_hold_byte0", out_data, er[7:0]);
            end
            if (acc) begin
                if (first < 0) first = n;
                last = n;
                idx++;
                seen_acc = 1'b1;
            end
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        if (mode == 0) check("throughput", 32'(last - first), NB - 1);
        check("accept_count", idx, NB);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [39:0] m;
        bit          op;
        logic [31:0] a, b;

        vecs[0] = '{op: 1'b0, a: 32'h1234_5678, b: 32'h1111_1111, r: 32'h2345_6789, st: 8'h00};
        vecs[1] = '{op: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, r: 32'h0000_0000, st: 8'h05};
        vecs[2] = '{op: 1'b0, a: 32'h7FFF_FFFF, b: 32'h0000_0001, r: 32'h8000_0000, st: 8'h02};
        vecs[3] = '{op: 1'b1, a: 32'h0000_0005, b: 32'h0000_0003, r: 32'h0000_0002, st: 8'h01};
        vecs[4] = '{op: 1'b1, a: 32'h0000_0003, b: 32'h0000_0005, r: 32'hFFFF_FFFE, st: 8'h00};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; op_sub = 1'b0;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;

        // Operand bytes offered while idle must not be taken.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check("idle_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].st, 0);

        run_op(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].r, vecs[0].st, 1);

        // Reset after two accepted beats aborts the operation.
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 8'h78; in_b = 8'h11;
        @(negedge clk);
        in_a = 8'h56;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        prev_acc   = 1'b0;

        // Start while disabled is dropped.
        @(negedge clk);
        ena = 1'b0; start = 1'b1;
        #1 check("ena_in_ready", in_ready, 0);
        @(negedge clk);
        start = 1'b0; ena = 1'b1;
        #1 check("ena_start_ignored", busy, 0);

        run_op(vecs[2].op, vecs[2].a, vecs[2].b, vecs[2].r, vecs[2].st, 0);

        for (int i = 0; i < 24; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 0) b = a;
            m  = model(op, a, b);
            run_op(op, a, b, m[31:0], m[39:32], (i % 4 == 0) ? 0 : 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
